wb_ram_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one `wb_ram` slave port among `nm` masters, such as the CPU instruction bus, the CPU data bus and a debug/DMA port. It holds the grant for the whole Wishbone cycle, including classic, incrementing and wrapping bursts. It forwards the granted master's signals to the RAM and routes `ack`/`err`/read data back to that master only. A per-transfer watchdog converts a missing acknowledge into a bus error, so a misconfigured slave cannot hang the SoC.

---
 rtl/wb_ram_arbiter_pkg.sv | 22 ++
 rtl/wb_rr_pick.sv | 36 +++
 rtl/wb_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter_pkg : shared state encodings, Wishbone cycle-type constants
// and the round-robin index helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_ram_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int rr_index(input int last, input int offset, input int n);
    return (last + offset) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick : combinational round-robin picker, one-hot result, searching
// from last+1 upward (modulo nm). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_rr_pick
  import wb_ram_arbiter_pkg::*;
#(
  parameter int nm = 2
) (
  input  logic [nm-1:0]         req,
  input  logic [$clog2(nm)-1:0] last,
  output logic [nm-1:0]         grant
);

  localparam int iw = $clog2(nm);

  logic [iw-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int off = nm; off >= 1; off--) begin
      cand = iw'(rr_index(int'(last), off, nm));
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter : round-robin Wishbone arbiter sharing one RAM slave among
// nm masters, with a per-transfer ack watchdog. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int nm      = 2,
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int timeout = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [nm*aw-1:0]     wbm_adr_i,
  input  logic [nm*dw-1:0]     wbm_dat_i,
  input  logic [nm*dw/8-1:0]   wbm_sel_i,
  input  logic [nm-1:0]        wbm_we_i,
  input  logic [nm-1:0]        wbm_cyc_i,
  input  logic [nm-1:0]        wbm_stb_i,
  input  logic [nm*3-1:0]      wbm_cti_i,
  input  logic [nm*2-1:0]      wbm_bte_i,
  output logic [nm-1:0]        wbm_ack_o,
  output logic [nm-1:0]        wbm_err_o,
  output logic [nm*dw-1:0]     wbm_dat_o,
  output logic [aw-1:0]        wbs_adr_o,
  output logic [dw-1:0]        wbs_dat_o,
  output logic [dw/8-1:0]      wbs_sel_o,
  output logic                 wbs_we_o,
  output logic [2:0]           wbs_cti_o,
  output logic [1:0]           wbs_bte_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic [dw-1:0]        wbs_dat_i,
  output logic [nm-1:0]        grant_o
);

  localparam int sw = dw / 8;
  localparam int iw = $clog2(nm);

  logic [0:0]    state, state_next;
  logic [nm-1:0] grant, grant_next, pick;
  logic [iw-1:0] last, last_next, owner;
  logic          busy, expire, to_err;

  logic [aw-1:0] adr_g;
  logic [dw-1:0] dat_g;
  logic [sw-1:0] sel_g;
  logic [2:0]    cti_g;
  logic [1:0]    bte_g;
  logic          we_g, cyc_g, stb_g;

  wb_rr_pick #(.nm(nm)) u_pick (
    .req   (wbm_cyc_i),
    .last  (last),
    .grant (pick)
  );

  assign busy = (state == ARB_BUSY);

  // Grant is one-hot or zero, so a plain priority walk acts as an AND-OR mux.
  always_comb begin
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    cti_g = '0;
    bte_g = '0;
    we_g  = 1'b0;
    cyc_g = 1'b0;
    stb_g = 1'b0;
    owner = '0;
    for (int k = 0; k < nm; k++) begin
      if (grant[k]) begin
        adr_g = wbm_adr_i[k*aw +: aw];
        dat_g = wbm_dat_i[k*dw +: dw];
        sel_g = wbm_sel_i[k*sw +: sw];
        cti_g = wbm_cti_i[k*3 +: 3];
        bte_g = wbm_bte_i[k*2 +: 2];
        we_g  = wbm_we_i[k];
        cyc_g = wbm_cyc_i[k];
        stb_g = wbm_stb_i[k];
        owner = iw'(k);
      end
    end
  end

  generate
    if (timeout > 0) begin : g_wd
      localparam int cw = $clog2(timeout + 1);
      localparam logic [cw-1:0] to_max = cw'(timeout);

      logic [cw-1:0] wd_cnt, wd_next;

      assign expire = busy & stb_g & (wd_cnt == to_max);

      always_comb begin
        wd_next = '0;
        if (busy && stb_g && !wbs_ack_i && !wbs_err_i && !expire)
          wd_next = (wd_cnt == to_max) ? wd_cnt : wd_cnt + 1'b1;
      end

      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) wd_cnt <= '0;
        else            wd_cnt <= wd_next;
      end
    end else begin : g_no_wd
      assign expire = 1'b0;
    end
  endgenerate

  // A real ack arriving on the expiry cycle wins over the synthetic error.
  assign to_err = expire & ~wbs_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= iw'(nm - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    case (state)
      ARB_IDLE: begin
        if (|wbm_cyc_i) begin
          state_next = ARB_BUSY;
          grant_next = pick;
        end
      end
      ARB_BUSY: begin
        if (!cyc_g) begin
          state_next = ARB_IDLE;
          grant_next = '0;
          last_next  = owner;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_comb begin
    wbs_adr_o = adr_g;
    wbs_dat_o = dat_g;
    wbs_sel_o = sel_g;
    wbs_we_o  = we_g;
    wbs_cti_o = cti_g;
    wbs_bte_o = bte_g;
    wbs_cyc_o = cyc_g;
    wbs_stb_o = stb_g & ~to_err;
    wbm_ack_o = grant & {nm{wbs_ack_i}};
    wbm_err_o = grant & {nm{wbs_err_i | to_err}};
    wbm_dat_o = busy ? {nm{wbs_dat_i}} : '0;
    grant_o   = grant;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_ram_arbiter : directed scoreboard bench for wb_ram_arbiter (nm=2,
// timeout=4) with a latency-programmable RAM slave model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [7:0]  wbm_sel_i;
  logic [1:0]  wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o, grant_o;
  logic [5:0]  wbm_cti_i;
  logic [3:0]  wbm_bte_i;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;

  int n_pass = 0;
  int n_total = 0;
  int lat = 1;
  int s_cnt;

  typedef struct {
    int          m;
    bit          err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_ram_arbiter #(.nm(2), .aw(32), .dw(32), .timeout(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_dat_o(wbm_dat_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_dat_i(wbs_dat_i),
    .grant_o(grant_o)
  );

  function automatic logic [31:0] rd(input logic [31:0] adr);
    return adr ^ 32'hC0DE_0000;
  endfunction

  // RAM model: registered ack after lat strobed cycles; lat=0 never acks.
  assign wbs_err_i = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack_i <= 1'b0;
      s_cnt     <= 0;
    end else begin
      wbs_ack_i <= 1'b0;
      if (wbs_cyc_o && wbs_stb_o && !wbs_ack_i) begin
        if (s_cnt + 1 == lat) begin
          wbs_ack_i <= 1'b1;
          wbs_dat_i <= rd(wbs_adr_o);
          s_cnt     <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else if (!(wbs_cyc_o && wbs_stb_o)) begin
        s_cnt <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push(input int m, input bit err, input bit chk, input logic [31:0] dat);
    exp_t e;
    e.m = m; e.err = err; e.chk = chk; e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    wbm_cyc_i[m]          = cyc;
    wbm_stb_i[m]          = cyc;
    wbm_we_i[m]           = 1'b0;
    wbm_adr_i[m*32 +: 32] = adr;
    wbm_dat_i[m*32 +: 32] = ~adr;
    wbm_sel_i[m*4 +: 4]   = 4'hF;
    wbm_cti_i[m*3 +: 3]   = cti;
    wbm_bte_i[m*2 +: 2]   = 2'b00;
  endtask

  task automatic wait_resp(input int m);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = wbm_ack_o[m] | wbm_err_o[m];
    end
    if (!got) begin
      n_total++;
      $display("FAIL wait_resp: master %0d got no response in 20 cycles, expected ack/err", m);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every response popped against the oldest expectation for that master.
  always @(negedge clk) begin : monitor
    int idx;
    for (int k = 0; k < 2; k++) begin
      if (wbm_ack_o[k] || wbm_err_o[k]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].m == k && idx < 0) idx = i;
        if (idx < 0) begin
          n_total++;
          $display("FAIL resp_unexpected: master %0d ack=%0b err=%0b, expected no response",
                   k, wbm_ack_o[k], wbm_err_o[k]);
        end else begin
          check("resp_ack", 64'(wbm_ack_o[k]), 64'(!sb[idx].err));
          check("resp_err", 64'(wbm_err_o[k]), 64'(sb[idx].err));
          if (sb[idx].chk) check("resp_data", 64'(wbm_dat_o[k*32 +: 32]), 64'(sb[idx].dat));
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
    check("rst_wbs_stb", 64'(wbs_stb_o), 64'd0);
    tick();
    rst_n = 1'b1;

    // T1: single classic read by master 0
    tick();
    set_m(0, 1'b1, 32'h10, 3'b000);
    push(0, 1'b0, 1'b1, rd(32'h10));
    @(negedge clk); check("t1_grant_idle", 64'(grant_o), 64'd0);
    tick();
    @(negedge clk);
    check("t1_grant", 64'(grant_o), 64'd1);
    check("t1_stb", 64'(wbs_stb_o), 64'd1);
    check("t1_adr", 64'(wbs_adr_o), 64'h10);
    wait_resp(0);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    @(negedge clk); check("t1_grant_held", 64'(grant_o), 64'd1);
    tick();
    @(negedge clk); check("t1_release", 64'(grant_o), 64'd0);

    // T2: simultaneous requests after reset, round-robin order
    do_reset();
    tick();
    set_m(0, 1'b1, 32'h20, 3'b000);
    set_m(1, 1'b1, 32'h30, 3'b000);
    push(0, 1'b0, 1'b1, rd(32'h20));
    push(1, 1'b0, 1'b1, rd(32'h30));
    @(negedge clk); check("t2_grant_idle", 64'(grant_o), 64'd0);
    tick();
    @(negedge clk); check("t2_grant_m0", 64'(grant_o), 64'd1);
    wait_resp(0);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    @(negedge clk); check("t2_drop_cycle", 64'(grant_o), 64'd1);
    tick();
    @(negedge clk); check("t2_idle_gap", 64'(grant_o), 64'd0);
    tick();
    @(negedge clk); check("t2_grant_m1", 64'(grant_o), 64'd2);
    wait_resp(1);
    tick();
    set_m(1, 1'b0, 32'h0, 3'b000);
    set_m(0, 1'b1, 32'h24, 3'b000);
    push(0, 1'b0, 1'b1, rd(32'h24));
    tick();
    set_m(1, 1'b1, 32'h34, 3'b000);
    push(1, 1'b0, 1'b1, rd(32'h34));
    @(negedge clk); check("t2_idle2", 64'(grant_o), 64'd0);
    tick();
    @(negedge clk); check("t2_rr_m0_again", 64'(grant_o), 64'd1);
    wait_resp(0);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    wait_resp(1);
    tick(); set_m(1, 1'b0, 32'h0, 3'b000);
    tick(); tick();

    // T3: 4-beat incrementing burst by master 1, master 0 requests mid-burst
    set_m(1, 1'b1, 32'h40, 3'b010);
    for (int b = 0; b < 4; b++) push(1, 1'b0, 1'b1, rd(32'h40 + 32'(4*b)));
    for (int b = 0; b < 4; b++) begin
      wait_resp(1);
      check("t3_grant_beat", 64'(grant_o), 64'd2);
      if (b == 3) check("t3_cti_eob", 64'(wbs_cti_o), 64'd7);
      tick();
      if (b < 3) set_m(1, 1'b1, 32'h44 + 32'(4*b), (b == 2) ? 3'b111 : 3'b010);
      else       set_m(1, 1'b0, 32'h0, 3'b000);
      if (b == 0) begin
        set_m(0, 1'b1, 32'h50, 3'b000);
        push(0, 1'b0, 1'b1, rd(32'h50));
      end
    end
    tick();
    tick();
    @(negedge clk); check("t3_m0_after", 64'(grant_o), 64'd1);
    wait_resp(0);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    tick(); tick();

    // T4: watchdog expiry with a silent slave
    lat = 0;
    set_m(0, 1'b1, 32'h60, 3'b000);
    push(0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("t4_no_err_yet", 64'(wbm_err_o[0]), 64'd0);
      check("t4_stb_high", 64'(wbs_stb_o), 64'd1);
    end
    tick();
    @(negedge clk);
    check("t4_err", 64'(wbm_err_o[0]), 64'd1);
    check("t4_stb_low", 64'(wbs_stb_o), 64'd0);
    tick();
    @(negedge clk);
    check("t4_err_one_cycle", 64'(wbm_err_o[0]), 64'd0);
    check("t4_stb_again", 64'(wbs_stb_o), 64'd1);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    tick(); tick();

    // T5: slave ack on the expiry cycle wins
    lat = 4;
    set_m(0, 1'b1, 32'h70, 3'b000);
    push(0, 1'b0, 1'b1, rd(32'h70));
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("t5_ack", 64'(wbm_ack_o[0]), 64'd1);
    check("t5_no_err", 64'(wbm_err_o[0]), 64'd0);
    check("t5_stb_kept", 64'(wbs_stb_o), 64'd1);
    tick(); set_m(0, 1'b0, 32'h0, 3'b000);
    tick(); tick();

    // T6: reset in the middle of a burst
    lat = 1;
    set_m(1, 1'b1, 32'h80, 3'b010);
    push(1, 1'b0, 1'b1, rd(32'h80));
    wait_resp(1);
    tick();
    set_m(1, 1'b1, 32'h84, 3'b010);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("t6_grant", 64'(grant_o), 64'd0);
    check("t6_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
    check("t6_wbs_stb", 64'(wbs_stb_o), 64'd0);
    check("t6_wbs_adr", 64'(wbs_adr_o), 64'd0);
    check("t6_ack", 64'(wbm_ack_o), 64'd0);
    check("t6_err", 64'(wbm_err_o), 64'd0);
    check("t6_dat", wbm_dat_o, 64'd0);
    tick();
    set_m(1, 1'b0, 32'h0, 3'b000);
    rst_n = 1'b1;
    tick(); tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
